// File: rtl/pipe_stage_fifo.sv
// Inter-stage buffer: DEPTH-entry circular FIFO with valid/ready handshake,
// flush-to-bubble and optional full-and-draining pass-through on in_ready.
module pipe_stage_fifo #(
   parameter int unsigned    WIDTH        = 41,
   parameter int unsigned    DEPTH        = 2,
   parameter bit             BYPASS_READY = 1'b0,
   parameter logic [WIDTH-1:0] BUBBLE     = '0,
   localparam int unsigned   CW = $clog2(DEPTH + 1),
   localparam int unsigned   PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $fatal(1, "pipe_stage_fifo: DEPTH must be within 1..16");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop, not_full;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign not_full  = (cnt_q < CW'(DEPTH));
   assign in_ready  = not_full | (BYPASS_READY & out_ready);
   assign out_valid = (cnt_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
   assign count     = cnt_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_d = cnt_q + CW'(1);
         else if (pop && !push) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload slots carry no reset; an empty buffer shows BUBBLE regardless.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: three configurations share one stimulus stream,
// each checked against an ordered-list model of its contents.
module tb_pipe_stage_fifo;

   localparam int W = 16;
   localparam int NDUT = 3;
   localparam int DEPTHS [NDUT] = '{2, 1, 3};
   localparam int BRS    [NDUT] = '{0, 1, 0};
   localparam logic [W-1:0] BUB = 16'hDEAD;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [W-1:0]  in_data;
   logic [NDUT-1:0] irdy, ovld;
   logic [W-1:0]  odat [NDUT];
   logic [7:0]    cnt  [NDUT];
   logic          chk_en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int D   = DEPTHS[g];
      localparam int CWL = $clog2(D + 1);
      logic [CWL-1:0] c;
      pipe_stage_fifo #(
         .WIDTH(W), .DEPTH(D),
         .BYPASS_READY(BRS[g] != 0), .BUBBLE(BUB)
      ) u_dut (
         .clk(clk), .rst(rst), .flush(flush),
         .in_valid(in_valid), .in_ready(irdy[g]), .in_data(in_data),
         .out_valid(ovld[g]), .out_ready(out_ready), .out_data(odat[g]),
         .count(c)
      );
      assign cnt[g] = 8'(c);
   end

   // Reference model: expected contents per DUT, oldest word at index 0.
   logic [W-1:0] sb [NDUT][16];
   int           n  [NDUT];

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d (depth %0d) at %0t: got %h want %h",
                  nm, k, DEPTHS[k], $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic ir_e, pop, push;
      if (chk_en) begin
         for (int k = 0; k < NDUT; k++) begin
            ir_e = (n[k] < DEPTHS[k]) || (BRS[k] != 0 && out_ready);
            chk("count", k, 32'(cnt[k]), 32'(n[k]));
            chk("in_ready", k, 32'(irdy[k]), 32'(ir_e));
            chk("out_valid", k, 32'(ovld[k]), 32'(n[k] != 0));
            pop  = (n[k] != 0) && out_ready;
            push = in_valid && ir_e;
            if (n[k] == 0)
               chk("bubble", k, 32'(odat[k]), 32'(BUB));
            else if (pop)
               chk("pop_data", k, 32'(odat[k]), 32'(sb[k][0]));
            else
               chk("hold_data", k, 32'(odat[k]), 32'(sb[k][0]));
            if (rst || flush) begin
               n[k] = 0;
            end else begin
               if (pop) begin
                  for (int j = 0; j < 15; j++) sb[k][j] = sb[k][j+1];
                  n[k]--;
               end
               if (push) begin
                  sb[k][n[k]] = in_data;
                  n[k]++;
               end
            end
         end
      end
   end

   task automatic step(input logic r, input logic fl, input logic v,
                       input logic [W-1:0] d, input logic ordy);
      rst = r; flush = fl; in_valid = v; in_data = d; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) n[k] = 0;
      chk_en = 1'b0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      step(1, 0, 0, 16'h0, 0);
      // Stream with downstream always ready
      for (int i = 0; i < 3; i++) step(0, 0, 1, 16'(16'h100 + i), 1);
      step(0, 0, 0, 16'h0, 1);
      step(0, 0, 0, 16'h0, 1);
      // Backpressure fill, refused word, single-cycle drain
      step(0, 0, 1, 16'hA, 0);
      step(0, 0, 1, 16'hB, 0);
      step(0, 0, 1, 16'hC, 0);
      step(0, 0, 1, 16'hC, 0);
      step(0, 0, 1, 16'hC, 1);
      step(0, 0, 1, 16'hC, 0);
      step(0, 0, 0, 16'h0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 1);
      // Continuous push, then stall while full
      for (int i = 1; i <= 8; i++) step(0, 0, 1, 16'(i), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 16'h77, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 1);
      // Flush with same-cycle push
      step(0, 0, 1, 16'h11, 0);
      step(0, 0, 1, 16'h22, 0);
      step(0, 1, 1, 16'h33, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 1);
      // Wrap-around: occupancy oscillates under alternating stalls
      for (int i = 0; i < 10; i++) step(0, 0, 1, 16'(i), (i % 3) == 2);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 16'h0, 1);
      // Reset mid-operation with traffic on both sides
      step(0, 0, 1, 16'h41, 0);
      step(0, 0, 1, 16'h42, 0);
      step(1, 0, 1, 16'h43, 1);
      step(0, 0, 1, 16'h5A, 0);
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 1);
      step(0, 0, 0, 16'h0, 1);
      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 79) == 0,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 3) != 0,
              16'($urandom),
              (i % 64) < 40 ? $urandom_range(0, 3) != 0
                            : $urandom_range(0, 3) == 0);
      end
      step(0, 0, 0, 16'h0, 1);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
